// File: rtl/frida_pkg.sv
// Shared types and helpers for the FRIDA on-chip SAR conversion sequencer.
package frida_pkg;

  localparam int DEF_N_ADC  = 16;
  localparam int DEF_N_BITS = 12;
  localparam int DEF_CNT_W  = 8;

  // Returned by next_en_chan when no enabled channel remains.
  localparam int NO_CHAN = 32;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SAMP,
    CMP,
    LOGIC,
    DRAIN
  } seq_state_t;

  // Lowest set bit of mask at index >= from, or NO_CHAN. Masks up to 32 channels.
  function automatic int next_en_chan(input logic [31:0] mask, input int from);
    int found;
    found = NO_CHAN;
    for (int i = 31; i >= 0; i--) begin
      if (i >= from && mask[i]) found = i;
    end
    return found;
  endfunction

endpackage

// File: rtl/frida_phase_timer.sv
// Phase down-counter shared by all four SAR phases; a zero duration behaves as one clock.
module frida_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] dur,
  input  logic             tick,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= (dur == '0) ? '0 : dur - CNT_W'(1);
    end else if (tick && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/frida_seq_gen.sv
// SAR conversion sequencer: generates init/samp/cmp/logic strobes, captures comparator
// decisions per enabled channel and drains finished codes over a valid/ready stream.
module frida_seq_gen
  import frida_pkg::*;
#(
  parameter int N_ADC  = DEF_N_ADC,
  parameter int N_BITS = DEF_N_BITS,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SEL_W  = $clog2(N_ADC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_cont,
  input  logic [CNT_W-1:0]  cfg_t_init,
  input  logic [CNT_W-1:0]  cfg_t_samp,
  input  logic [CNT_W-1:0]  cfg_t_cmp,
  input  logic [CNT_W-1:0]  cfg_t_logic,
  input  logic [N_ADC-1:0]  cfg_adc_en,
  input  logic [N_ADC-1:0]  comp_in,
  output logic              seq_init,
  output logic              seq_samp,
  output logic              seq_cmp,
  output logic              seq_logic,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_BITS-1:0] res_data,
  output logic [SEL_W-1:0]  res_chan
);

  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  seq_state_t         r_state;
  logic [CNT_W-1:0]   r_t_samp, r_t_cmp, r_t_logic;
  logic               r_cont;
  logic [N_ADC-1:0]   r_en;
  logic [BIT_W-1:0]   r_bit;
  logic [N_BITS-1:0]  r_code [N_ADC];
  logic [SEL_W-1:0]   r_chan;
  logic [N_BITS-1:0]  r_res_data;
  logic               r_valid, r_done, r_busy;
  logic               r_seq_init, r_seq_samp, r_seq_cmp, r_seq_logic;

  seq_state_t         w_next;
  logic               w_load, w_expire;
  logic [CNT_W-1:0]   w_dur;
  int                 w_first, w_after;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_first = next_en_chan(32'(r_en), 0);
    w_after = next_en_chan(32'(r_en), int'(r_chan) + 1);
    w_next  = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = INIT;
      INIT:  if (w_expire) w_next = SAMP;
      SAMP:  if (w_expire) w_next = CMP;
      CMP:   if (w_expire) w_next = LOGIC;
      LOGIC: if (w_expire) w_next = (r_bit == BIT_W'(N_BITS - 1)) ? DRAIN : CMP;
      DRAIN: begin
        // First DRAIN cycle selects a channel; later cycles advance on each handshake.
        if ((!r_valid && r_en == '0) || (r_valid && res_ready && w_after >= N_ADC))
          w_next = r_cont ? INIT : IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (stop) w_next = IDLE;
  end

  // The timer is reloaded on every state change with the duration of the state being entered.
  // INIT takes its length straight from the input, as the shadows latch on that same edge.
  always_comb begin
    w_load = (w_next != r_state);
    unique case (w_next)
      SAMP:    w_dur = r_t_samp;
      CMP:     w_dur = r_t_cmp;
      LOGIC:   w_dur = r_t_logic;
      default: w_dur = cfg_t_init;
    endcase
  end

  frida_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .dur    (w_dur),
    .tick   (r_busy),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_seq_init  <= 1'b0;
      r_seq_samp  <= 1'b0;
      r_seq_cmp   <= 1'b0;
      r_seq_logic <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_chan      <= '0;
      r_res_data  <= '0;
      r_bit       <= '0;
      r_en        <= '0;
      r_cont      <= 1'b0;
      r_t_samp    <= '0;
      r_t_cmp     <= '0;
      r_t_logic   <= '0;
      // NOTE: the code array is reset too; it is only N_ADC small registers, not a RAM.
      for (int i = 0; i < N_ADC; i++) r_code[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_seq_init  <= (w_next == INIT);
      r_seq_samp  <= (w_next == SAMP);
      r_seq_cmp   <= (w_next == CMP);
      r_seq_logic <= (w_next == LOGIC);
      r_busy      <= (w_next != IDLE);
      r_done      <= (r_state == DRAIN) && (w_next != DRAIN) && !stop;

      if (w_next == INIT && r_state != INIT) begin
        r_t_samp  <= cfg_t_samp;
        r_t_cmp   <= cfg_t_cmp;
        r_t_logic <= cfg_t_logic;
        r_cont    <= cfg_cont;
        r_en      <= cfg_adc_en;
        r_bit     <= '0;
        for (int i = 0; i < N_ADC; i++) r_code[i] <= '0;
      end

      if (r_state == CMP && w_expire) begin
        for (int i = 0; i < N_ADC; i++) begin
          if (r_en[i]) r_code[i] <= {r_code[i][N_BITS-2:0], comp_in[i]};
        end
      end

      if (r_state == LOGIC && w_expire) r_bit <= r_bit + BIT_W'(1);

      if (r_state == DRAIN) begin
        if (!r_valid) begin
          if (r_en != '0) begin
            r_valid    <= 1'b1;
            r_chan     <= SEL_W'(w_first);
            r_res_data <= r_code[SEL_W'(w_first)];
          end
        end else if (res_ready && w_after < N_ADC) begin
          r_chan     <= SEL_W'(w_after);
          r_res_data <= r_code[SEL_W'(w_after)];
        end
      end

      if (w_next != DRAIN) begin
        r_valid    <= 1'b0;
        r_chan     <= '0;
        r_res_data <= '0;
      end
    end
  end

  assign seq_init  = r_seq_init;
  assign seq_samp  = r_seq_samp;
  assign seq_cmp   = r_seq_cmp;
  assign seq_logic = r_seq_logic;
  assign busy      = r_busy;
  assign done      = r_done;
  assign res_valid = r_valid;
  assign res_data  = r_res_data;
  assign res_chan  = r_chan;

endmodule

// File: tb/tb_frida_seq_gen.sv
// Scoreboard bench for frida_seq_gen: a schedule model predicts strobes, captured codes and done.
module tb_frida_seq_gen;

  localparam int N_ADC  = 16;
  localparam int N_BITS = 4;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 4;

  logic              clk = 1'b0;
  logic              reset, start, stop, cfg_cont;
  logic [CNT_W-1:0]  cfg_t_init, cfg_t_samp, cfg_t_cmp, cfg_t_logic;
  logic [N_ADC-1:0]  cfg_adc_en, comp_in;
  logic              seq_init, seq_samp, seq_cmp, seq_logic, busy, done, res_valid, res_ready;
  logic [N_BITS-1:0] res_data;
  logic [SEL_W-1:0]  res_chan;

  frida_seq_gen #(.N_ADC(N_ADC), .N_BITS(N_BITS), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_cont(cfg_cont),
    .cfg_t_init(cfg_t_init), .cfg_t_samp(cfg_t_samp), .cfg_t_cmp(cfg_t_cmp),
    .cfg_t_logic(cfg_t_logic), .cfg_adc_en(cfg_adc_en), .comp_in(comp_in),
    .seq_init(seq_init), .seq_samp(seq_samp), .seq_cmp(seq_cmp), .seq_logic(seq_logic),
    .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_chan(res_chan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                chan;
    logic [N_BITS-1:0] data;
    bit                last;
  } res_t;

  int               cyc = 0;
  int               n_vec = 0;
  int               n_err = 0;
  int               rdy_mode = 1;    // 0 random, 1 always ready, 2 stalled
  res_t             sb [$];
  int               exp_ph [int];    // cycle -> 1 init, 2 samp, 3 cmp, 4 logic
  logic [N_ADC-1:0] comp_plan [int]; // cycle -> comparator word captured at its end
  bit               exp_done [int];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Conversion schedule from the phase-length rules; records strobes, capture words and results.
  task automatic plan_conv(input int s, input int ti, input int ts, input int tc, input int tl,
                           input logic [N_ADC-1:0] en, input int pat, input int abort_at,
                           output int next_s);
    int                t, n_en, last_ch;
    int                len [4];
    logic [N_ADC-1:0]  v;
    logic [N_BITS-1:0] code [N_ADC];
    len[0] = (ti < 1) ? 1 : ti;
    len[1] = (ts < 1) ? 1 : ts;
    len[2] = (tc < 1) ? 1 : tc;
    len[3] = (tl < 1) ? 1 : tl;
    for (int i = 0; i < N_ADC; i++) code[i] = '0;
    t = s;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < len[p]; k++) begin
        if (abort_at < 0 || t <= abort_at) exp_ph[t] = p + 1;
        t++;
      end
    for (int b = 0; b < N_BITS; b++) begin
      for (int k = 0; k < len[2]; k++) begin
        if (abort_at < 0 || t <= abort_at) exp_ph[t] = 3;
        t++;
      end
      v = N_ADC'($urandom);
      if (pat >= 0) v[0] = pat[N_BITS-1-b];
      comp_plan[t-1] = v;
      for (int i = 0; i < N_ADC; i++) code[i][N_BITS-1-b] = v[i];
      for (int k = 0; k < len[3]; k++) begin
        if (abort_at < 0 || t <= abort_at) exp_ph[t] = 4;
        t++;
      end
    end
    n_en = $countones(en);
    last_ch = -1;
    for (int i = 0; i < N_ADC; i++) if (en[i]) last_ch = i;
    if (abort_at < 0) begin
      for (int i = 0; i < N_ADC; i++)
        if (en[i]) sb.push_back('{chan: i, data: code[i], last: (i == last_ch)});
      if (n_en == 0) exp_done[t+1] = 1'b1;
    end
    next_s = t + 1 + n_en;  // next INIT when the stream never stalls
  endtask

  task automatic set_cfg(input int ti, input int ts, input int tc, input int tl,
                         input logic [N_ADC-1:0] en, input bit cont);
    cfg_t_init  = CNT_W'(ti);
    cfg_t_samp  = CNT_W'(ts);
    cfg_t_cmp   = CNT_W'(tc);
    cfg_t_logic = CNT_W'(tl);
    cfg_adc_en  = en;
    cfg_cont    = cont;
  endtask

  task automatic fire(input int pat, output int s);
    int nxt;
    start = 1'b1;
    s = cyc + 1;
    plan_conv(s, int'(cfg_t_init), int'(cfg_t_samp), int'(cfg_t_cmp), int'(cfg_t_logic),
              cfg_adc_en, pat, -1, nxt);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", 64'(n >= budget), 64'd0);
    tick();
    tick();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    check("res_valid_seen", 64'(res_valid), 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({seq_init, seq_samp, seq_cmp, seq_logic, busy, done, res_valid, res_data, res_chan});
  endfunction

  initial begin
    res_ready = 1'b0;
    forever begin
      tick();
      case (rdy_mode)
        0:       res_ready = 1'($urandom_range(0, 1));
        1:       res_ready = 1'b1;
        default: res_ready = 1'b0;
      endcase
    end
  end

  initial begin
    comp_in = '0;
    forever begin
      tick();
      comp_in = comp_plan.exists(cyc) ? comp_plan[cyc] : N_ADC'($urandom);
    end
  end

  // Monitor: strobe timeline, stall stability, in-order results and the done pulse.
  logic [3:0]        m_exp_st;
  logic              m_prev_stall = 1'b0, m_prev_rst = 1'b1;
  logic [N_BITS-1:0] m_prev_data;
  logic [SEL_W-1:0]  m_prev_chan;
  int                m_pend_done = -1;
  res_t              m_e;

  always @(negedge clk) begin
    if (reset) begin
      m_prev_stall = 1'b0;
      m_prev_rst   = 1'b1;
      m_pend_done  = -1;
    end else begin
      m_exp_st = exp_ph.exists(cyc) ? (4'b1000 >> (exp_ph[cyc] - 1)) : 4'b0000;
      check("strobes", 64'({seq_init, seq_samp, seq_cmp, seq_logic}), 64'(m_exp_st));
      if (exp_ph.exists(cyc)) check("busy", 64'(busy), 64'd1);
      if (m_prev_stall && !m_prev_rst) begin
        check("hold_valid", 64'(res_valid), 64'd1);
        check("hold_data", 64'(res_data), 64'(m_prev_data));
        check("hold_chan", 64'(res_chan), 64'(m_prev_chan));
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result at cycle %0d: got chan %0d, expected none", cyc, res_chan);
        end else begin
          m_e = sb.pop_front();
          check("res_chan", 64'(res_chan), 64'(m_e.chan));
          check("res_data", 64'(res_data), 64'(m_e.data));
          if (m_e.last) m_pend_done = cyc + 1;
        end
      end
      check("done", 64'(done), 64'((m_pend_done == cyc) || exp_done.exists(cyc)));
      m_prev_stall = res_valid && !res_ready;
      m_prev_data  = res_data;
      m_prev_chan  = res_chan;
      m_prev_rst   = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, s2, nxt, a, cnt;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    set_cfg(0, 0, 0, 0, '0, 1'b0);
    repeat (3) tick();
    check("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    tick();

    // Single channel, fixed pattern 1,0,1,1: 2+3+4*(1+2) conversion clocks plus a 2-cycle drain.
    set_cfg(2, 3, 1, 2, 16'h0001, 1'b0);
    rdy_mode = 1;
    tick();
    fire(4'b1011, s);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
    check("busy_len", 64'(cnt), 64'd19);
    wait_idle(100);

    // Four channels drained in order while the stream stalls for 5 cycles.
    set_cfg(1, 1, 1, 1, 16'h8421, 1'b0);
    rdy_mode = 2;
    tick();
    fire(-1, s);
    wait_valid(200);
    repeat (5) tick();
    rdy_mode = 1;
    wait_idle(200);

    // Zero phase lengths act as one clock; an empty mask still runs and pulses done.
    set_cfg(0, 0, 0, 0, 16'h0000, 1'b0);
    rdy_mode = 0;
    fire(-1, s);
    wait_idle(200);

    // Continuous mode; a samp change during conversion 1 applies only to conversion 2.
    set_cfg(2, 3, 1, 1, 16'h0003, 1'b1);
    rdy_mode = 1;
    tick();
    start = 1'b1;
    s = cyc + 1;
    plan_conv(s, 2, 3, 1, 1, 16'h0003, -1, -1, s2);
    plan_conv(s2, 2, 5, 1, 1, 16'h0003, -1, -1, nxt);
    tick();
    start = 1'b0;
    tick();
    cfg_t_samp = CNT_W'(5);
    cfg_cont   = 1'b0;
    wait_idle(300);

    // Stop during the first CMP cycle of bit 2: everything drops, no done, no results.
    set_cfg(1, 2, 2, 1, 16'hFFFF, 1'b0);
    start = 1'b1;
    s = cyc + 1;
    a = s + 1 + 2 + 2 * (2 + 1);
    plan_conv(s, 1, 2, 2, 1, 16'hFFFF, -1, a, nxt);
    tick();
    start = 1'b0;
    while (cyc < a) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_outputs", all_outs(), 64'd0);
    repeat (4) tick();
    check("stop_no_done_idle", 64'({busy, done}), 64'd0);

    // Clean conversion after the abort, with a start pulse while busy that must be ignored.
    set_cfg(1, 2, 2, 1, 16'h00F0, 1'b0);
    fire(-1, s);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(300);

    // Reset while a result is presented.
    set_cfg(1, 1, 1, 1, 16'h0011, 1'b0);
    rdy_mode = 2;
    tick();
    fire(-1, s);
    wait_valid(200);
    reset = 1'b1;
    tick();
    check("reset_mid_drain", all_outs(), 64'd0);
    reset = 1'b0;
    sb.delete();
    rdy_mode = 1;
    repeat (3) tick();

    // Randomised conversions.
    for (int i = 0; i < 6; i++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? '0 : N_ADC'($urandom), 1'b0);
      rdy_mode = $urandom_range(0, 1);
      fire(-1, s);
      if (i % 2 == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_idle(600);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
